// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam int          INSTR_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC owner and single-outstanding instruction cache requester.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int               DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_f,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_target,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] read_data_f,
   output logic [DATA_WIDTH-1:0] PC_f,
   output logic [DATA_WIDTH-1:0] PCPlus4_f,
   output logic                  valid_f
);

   localparam logic [DATA_WIDTH-1:0] C_NOP  = DATA_WIDTH'(NOP_INSTR);
   localparam logic [DATA_WIDTH-1:0] C_STEP = DATA_WIDTH'(INSTR_BYTES);

   fetch_state_t          r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt;
   logic [DATA_WIDTH-1:0] r_inst, w_inst_nxt;
   logic [DATA_WIDTH-1:0] w_pc_plus4;

   assign w_pc_plus4 = r_pc + C_STEP;
   assign imem_addr  = r_pc;
   assign PC_f       = r_pc;
   assign PCPlus4_f  = w_pc_plus4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= REQ;
         r_pc    <= RESET_PC;
         r_inst  <= C_NOP;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_inst  <= w_inst_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_inst_nxt  = r_inst;
      imem_req    = 1'b0;
      valid_f     = 1'b0;
      read_data_f = C_NOP;

      case (r_state)
         REQ: begin
            imem_req = !redirect_valid;
            if (redirect_valid) begin
               w_pc_nxt = redirect_target;
            end else if (imem_ready) begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               valid_f     = 1'b1;
               read_data_f = imem_rdata;
            end
            if (redirect_valid) begin
               // An unanswered request must have its late response swallowed
               w_pc_nxt    = redirect_target;
               w_state_nxt = imem_rvalid ? REQ : DROP;
            end else if (imem_rvalid) begin
               if (!stall_f) begin
                  w_pc_nxt    = w_pc_plus4;
                  w_state_nxt = REQ;
               end else begin
                  w_inst_nxt  = imem_rdata;
                  w_state_nxt = HOLD;
               end
            end
         end
         DROP: begin
            if (redirect_valid) begin
               w_pc_nxt = redirect_target;
            end
            if (imem_rvalid) begin
               w_state_nxt = REQ;
            end
         end
         HOLD: begin
            valid_f     = 1'b1;
            read_data_f = r_inst;
            if (redirect_valid) begin
               w_pc_nxt    = redirect_target;
               w_state_nxt = REQ;
            end else if (!stall_f) begin
               w_pc_nxt    = w_pc_plus4;
               w_state_nxt = REQ;
            end
         end
         default: begin
            w_state_nxt = REQ;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed and randomized self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_f, redirect_valid, imem_ready, imem_rvalid;
   logic [31:0] redirect_target, imem_rdata;
   logic        imem_req, valid_f;
   logic [31:0] imem_addr, read_data_f, PC_f, PCPlus4_f;

   int n_checks = 0;
   int n_errors = 0;

   fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .stall_f(stall_f),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .read_data_f(read_data_f), .PC_f(PC_f), .PCPlus4_f(PCPlus4_f),
      .valid_f(valid_f)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a PC, whether a wanted or an unwanted response is owed
   // by the cache, and whether an instruction is parked waiting for decode.
   logic [31:0] m_pc = 32'h0, m_inst = NOP;
   logic        m_want = 1'b0, m_stale = 1'b0, m_have = 1'b0;
   logic [31:0] n_pc, n_inst;
   logic        n_want, n_stale, n_have;
   logic        issued_q = 1'b0;

   always @(negedge clk) begin
      logic        e_req, e_valid, busy;
      logic [31:0] e_data;
      if (rst) begin
         m_pc = 32'h0; m_inst = NOP; m_want = 0; m_stale = 0; m_have = 0;
      end
      busy    = m_want | m_stale | m_have;
      e_req   = !busy && !redirect_valid;
      e_valid = m_have || (m_want && imem_rvalid);
      e_data  = m_have ? m_inst : (m_want && imem_rvalid) ? imem_rdata : NOP;
      chk("m_req",     {31'b0, imem_req}, {31'b0, e_req});
      chk("m_valid",   {31'b0, valid_f},  {31'b0, e_valid});
      chk("m_data",    read_data_f,       e_data);
      chk("m_addr",    imem_addr,         m_pc);
      chk("m_pc",      PC_f,              m_pc);
      chk("m_pcplus4", PCPlus4_f,         m_pc + 32'd4);

      n_pc = m_pc; n_inst = m_inst; n_want = m_want; n_stale = m_stale; n_have = m_have;
      if (redirect_valid) begin
         n_pc    = redirect_target;
         n_stale = (m_want && !imem_rvalid) || (m_stale && !imem_rvalid);
         n_want  = 1'b0;
         n_have  = 1'b0;
      end else begin
         if (e_valid && !stall_f) n_pc = m_pc + 32'd4;
         if (e_req && imem_ready) n_want = 1'b1;
         if (m_want && imem_rvalid) begin
            n_want = 1'b0;
            if (stall_f) begin
               n_have = 1'b1;
               n_inst = imem_rdata;
            end
         end
         if (m_have && !stall_f) n_have = 1'b0;
         if (m_stale && imem_rvalid) n_stale = 1'b0;
      end
      issued_q = imem_req && imem_ready && !rst;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_pc = 32'h0; m_inst = NOP; m_want = 0; m_stale = 0; m_have = 0;
      end else begin
         m_pc = n_pc; m_inst = n_inst; m_want = n_want; m_stale = n_stale; m_have = n_have;
      end
   end

   task automatic step(input logic rs, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rdr, input logic [31:0] tgt);
      @(posedge clk); #1;
      rst = rs; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
      stall_f = st; redirect_valid = rdr; redirect_target = tgt;
      @(negedge clk);
   endtask

   initial begin
      logic        c_pend;
      int          c_dly;
      logic        rs, rv;
      logic [31:0] tmp;

      rst = 1; stall_f = 0; redirect_valid = 0; redirect_target = 0;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
      @(negedge clk);
      chk("rst_req", {31'b0, imem_req}, 32'd1);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_plus4", PCPlus4_f, 32'h4);
      chk("rst_valid", {31'b0, valid_f}, 32'd0);
      chk("rst_data", read_data_f, NOP);

      // Straight-line fetch with a 1-cycle cache
      step(0,1,0,0,0,0,0);            chk("t1_addr0", imem_addr, 32'h0);
      step(0,1,1,32'h11,0,0,0);       chk("t1_pc0", PC_f, 32'h0); chk("t1_v0", {31'b0, valid_f}, 32'd1);
                                      chk("t1_p4_0", PCPlus4_f, 32'h4);
      step(0,1,0,0,0,0,0);            chk("t1_addr4", imem_addr, 32'h4);
      step(0,1,1,32'h22,0,0,0);       chk("t1_pc4", PC_f, 32'h4); chk("t1_p4_4", PCPlus4_f, 32'h8);
      step(0,1,0,0,0,0,0);            chk("t1_addr8", imem_addr, 32'h8);
      step(0,1,1,32'h33,0,0,0);       chk("t1_p4_8", PCPlus4_f, 32'hC); chk("t1_d8", read_data_f, 32'h33);

      // Decode stall holds the instruction
      step(0,1,0,0,0,0,0);            chk("t2_addr", imem_addr, 32'hC);
      step(0,1,1,32'h00A00093,1,0,0); chk("t2_d0", read_data_f, 32'h00A00093);
      for (int i = 0; i < 2; i++) begin
         step(0,1,0,0,1,0,0);
         chk("t2_hold_d", read_data_f, 32'h00A00093);
         chk("t2_hold_req", {31'b0, imem_req}, 32'd0);
      end
      step(0,1,0,0,0,0,0);            chk("t2_rel_v", {31'b0, valid_f}, 32'd1);
      step(0,1,0,0,0,0,0);            chk("t2_next", imem_addr, 32'h10);

      // Redirect while waiting: late response discarded
      step(0,1,0,0,0,1,32'h100);      chk("t3_v", {31'b0, valid_f}, 32'd0);
      step(0,1,0,0,0,0,0);            chk("t3_req", {31'b0, imem_req}, 32'd0);
      step(0,1,1,32'hDEADBEEF,0,0,0); chk("t3_drop_v", {31'b0, valid_f}, 32'd0);
                                      chk("t3_drop_d", read_data_f, NOP);
      step(0,1,0,0,0,0,0);            chk("t3_addr", imem_addr, 32'h100);

      // Redirect coincident with the response
      step(0,1,1,32'h44,0,1,32'h200); chk("t4_v", {31'b0, valid_f}, 32'd1);
      step(0,0,0,0,0,0,0);            chk("t4_addr", imem_addr, 32'h200);

      // Cache miss: not ready, then slow response
      for (int i = 0; i < 3; i++) begin
         step(0,0,0,0,0,0,0);         chk("t5_nr_v", {31'b0, valid_f}, 32'd0);
      end
      step(0,1,0,0,0,0,0);
      for (int i = 0; i < 4; i++) begin
         step(0,1,0,0,0,0,0);
         chk("t5_w_v", {31'b0, valid_f}, 32'd0);
         chk("t5_w_d", read_data_f, NOP);
      end
      step(0,1,1,32'h55,0,0,0);       chk("t5_pc", PC_f, 32'h200);

      // Reset in WAIT, then PC wrap
      step(0,1,0,0,0,0,0);            chk("t6_addr", imem_addr, 32'h204);
      step(1,1,0,0,0,0,0);            chk("t6_rst_addr", imem_addr, 32'h0);
                                      chk("t6_rst_req", {31'b0, imem_req}, 32'd1);
      step(0,0,0,0,0,1,32'hFFFF_FFFC);
      step(0,1,0,0,0,0,0);            chk("t6_wrap_p4", PCPlus4_f, 32'h0);
      step(0,1,1,32'h66,0,0,0);
      step(0,0,0,0,0,0,0);            chk("t6_wrap_addr", imem_addr, 32'h0);
      step(1,0,0,0,0,0,0);

      // Randomized traffic against a well-behaved cache
      c_pend = 0; c_dly = 0;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         if (issued_q) begin
            c_pend = 1;
            c_dly  = $urandom_range(0, 3);
         end
         rs = ($urandom_range(0, 199) == 0);
         if (rs) begin
            c_pend = 0; rv = 0;
         end else if (c_pend && c_dly == 0) begin
            rv = 1; c_pend = 0;
         end else begin
            rv = 0;
            if (c_pend) c_dly--;
         end
         rst            = rs;
         imem_rvalid    = rv;
         imem_rdata     = $urandom;
         imem_ready     = ($urandom_range(0, 9) < 7);
         stall_f        = ($urandom_range(0, 9) < 3);
         redirect_valid = ($urandom_range(0, 9) == 0);
         tmp            = $urandom;
         redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (tmp & 32'hC))
                                                       : (tmp & 32'hFFFF_FFFC);
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
